mips_muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit with HI/LO registers for the MIPS core.

---
 rtl/mips_muldiv_pkg.sv | 16 +
 rtl/mips_muldiv_if.sv | 17 +
 rtl/mips_muldiv_iter.sv | 31 +++
 rtl/mips_muldiv_unit.sv | 85 ++++++++
 tb/tb_mips_muldiv_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared op/state encodings and op-class helpers for the MIPS mul/div unit
package mips_muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_RSV6, OP_RSV7
  } op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;
  function automatic logic is_mul(op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU};
  endfunction
  function automatic logic is_signed(op_e op);
    return op inside {OP_MULT, OP_DIV, OP_MADD};
  endfunction
  function automatic logic is_div(op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction
endpackage

// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: controller <-> mul/div unit bus (issue, MTHI/MTLO writes, status, HI/LO); master=controller, slave=unit
interface mips_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, op, a, b, hi_we, lo_we, wdata, input busy, done, div_by_zero, hi, lo);
  modport slave(input start, op, a, b, hi_we, lo_we, wdata, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/mips_muldiv_iter.sv
// mips_muldiv_iter: radix-2 shift-add multiply / restoring divide step datapath (clk, rst, load, step, mul, x, y -> acc)
module mips_muldiv_iter #(parameter int WIDTH = 32) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               mul,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] acc
);
  logic [WIDTH-1:0] m;
  logic [WIDTH:0] opx, opy, sum;
  // Multiply: acc = {partial, multiplier}, shifts right. Divide: acc = {remainder, quotient}, shifts left.
  // One shared adder: add for multiply, subtract (x + ~y + 1) for divide; sum[WIDTH] is the divide borrow.
  always_comb begin
    opx = mul ? {1'b0, acc[2*WIDTH-1:WIDTH]} : {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    opy = mul ? (acc[0] ? {1'b0, m} : '0) : ~{1'b0, m};
    sum = opx + opy + {{WIDTH{1'b0}}, ~mul};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      m <= '0;
    end else if (load) begin
      acc <= {{WIDTH{1'b0}}, mul ? y : x};
      m <= mul ? x : y;
    end else if (step)
      acc <= mul ? {sum, acc[WIDTH-1:1]}
                 : {sum[WIDTH] ? opx[WIDTH-1:0] : sum[WIDTH-1:0], acc[WIDTH-2:0], ~sum[WIDTH]};
endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU (+MADD/MADDU when MULDIV_MADD_EN) with HI/LO; ports clk, rst, bus (mips_muldiv_if.slave)
module mips_muldiv_unit import mips_muldiv_pkg::*; #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst,
  mips_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_e state, state_n;
  op_e op_q;
  logic [CW-1:0] cnt;
  logic first, done_q, dbz_q, op_ok, accept, load, step, fix, a_neg, b_neg;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, a_mag, b_mag, q_s, r_s;
  logic [2*WIDTH-1:0] acc, prod_s, res;
`ifdef MULDIV_MADD_EN
  assign op_ok = bus.op <= 3'd5;
`else
  assign op_ok = bus.op <= 3'd3;
`endif
  assign accept = state == IDLE && bus.start && op_ok;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (accept ? CALC : IDLE)
            : state == CALC ? (step && cnt == CW'(WIDTH - 1) ? FIX : CALC)
            : IDLE;
  // The first CALC cycle loads magnitudes into the iterator; the next WIDTH cycles step.
  always_comb begin
    bus.busy = state != IDLE;
    load = state == CALC && first;
    step = state == CALC && !first;
    fix = state == FIX;
  end
  always_comb begin
    a_neg = is_signed(op_q) && a_q[WIDTH-1];
    b_neg = is_signed(op_q) && b_q[WIDTH-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    prod_s = (a_neg ^ b_neg) ? -acc : acc;
    q_s = (a_neg ^ b_neg) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_s = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res = is_mul(op_q) ? prod_s : dbz_q ? {a_q, {WIDTH{1'b1}}} : {r_s, q_s};
`ifdef MULDIV_MADD_EN
    if (op_q == OP_MADD || op_q == OP_MADDU) res = {hi_q, lo_q} + prod_s;
`endif
  end
  mips_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk(clk), .rst(rst), .load(load), .step(step), .mul(is_mul(op_q)),
    .x(a_mag), .y(b_mag), .acc(acc)
  );
  // MTHI/MTLO are honoured only when idle and not colliding with an accepted start.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_q <= OP_MULT;
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
      first <= 1'b0;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      done_q <= fix;
      if (accept) begin
        op_q <= op_e'(bus.op);
        a_q <= bus.a;
        b_q <= bus.b;
        dbz_q <= is_div(op_e'(bus.op)) && bus.b == '0;
        cnt <= '0;
        first <= 1'b1;
      end
      if (load) first <= 1'b0;
      if (step) cnt <= cnt + 1'b1;
      if (fix) {hi_q, lo_q} <= res;
      else if (state == IDLE && !accept) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  assign bus.done = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: table-driven self-checking bench for mips_muldiv_unit (WIDTH=32)
module tb_mips_muldiv_unit;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int lat;
  int seen;
  vec_t v[14];
  mips_muldiv_if #(.WIDTH(32)) bus();
  mips_muldiv_unit #(.WIDTH(32)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int l);
    int n;
    l = 0;
    n = 0;
    while (l == 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) l = n;
    end
  endtask
  initial begin
    v[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    v[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    v[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    v[3]  = '{3'd3, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF, 1'b1};
    v[4]  = '{3'd1, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0};
    v[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    v[6]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    v[7]  = '{3'd2, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    v[8]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    v[9]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    v[10] = '{3'd1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    v[11] = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    v[12] = '{3'd2, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
    v[13] = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = '0;
    bus.b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    chk("rst_dbz", {31'b0, bus.div_by_zero}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) begin
      issue(v[i].op, v[i].a, v[i].b);
      chk($sformatf("v%0d_busy_on", i), {31'b0, bus.busy}, 32'h1);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd34);
      chk($sformatf("v%0d_hi", i), bus.hi, v[i].hi);
      chk($sformatf("v%0d_lo", i), bus.lo, v[i].lo);
      chk($sformatf("v%0d_dbz", i), {31'b0, bus.div_by_zero}, {31'b0, v[i].dbz});
      chk($sformatf("v%0d_busy_off", i), {31'b0, bus.busy}, 32'h0);
    end
    issue(3'd2, 32'hFFFFFFF9, 32'h2);
    wait_done(lat);
    chk("b2b_div_lo", bus.lo, 32'hFFFFFFFD);
    issue(3'd3, 32'd100, 32'd7);
    chk("b2b_done_drop", {31'b0, bus.done}, 32'h0);
    chk("b2b_busy", {31'b0, bus.busy}, 32'h1);
    wait_done(lat);
    chk("b2b_latency", lat, 32'd34);
    chk("b2b_hi", bus.hi, 32'd2);
    chk("b2b_lo", bus.lo, 32'd14);
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD0001;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    chk("mthi", bus.hi, 32'hDEAD0001);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5;
    @(posedge clk);
    #1;
    bus.lo_we = 1'b0;
    chk("mtlo", bus.lo, 32'h5);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h55;
    issue(3'd1, 32'd2, 32'd3);
    bus.hi_we = 1'b0;
    chk("start_beats_we", bus.hi, 32'hDEAD0001);
    wait_done(lat);
    chk("collide_lo", bus.lo, 32'd6);
    chk("collide_hi", bus.hi, 32'd0);
    issue(3'd1, 32'd3, 32'd5);
    bus.start = 1'b1;
    bus.op = 3'd0;
    bus.a = 32'd9;
    bus.b = 32'd9;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1234;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    chk("busy_we_hi", bus.hi, 32'd0);
    chk("busy_we_lo", bus.lo, 32'd6);
    wait_done(lat);
    chk("busy_ign_latency", lat, 32'd31);
    chk("busy_ign_lo", bus.lo, 32'd15);
    chk("busy_ign_hi", bus.hi, 32'd0);
    issue(3'd1, 32'd7, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    chk("midrst_busy", {31'b0, bus.busy}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    chk("midrst_no_done", seen, 32'd0);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5;
    @(posedge clk);
    #1;
    bus.lo_we = 1'b0;
    issue(3'd6, 32'd3, 32'd4);
    chk("op6_busy", {31'b0, bus.busy}, 32'h0);
    chk("op6_lo", bus.lo, 32'h5);
`ifdef MULDIV_MADD_EN
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    issue(3'd5, 32'd3, 32'd4);
    chk("maddu_busy", {31'b0, bus.busy}, 32'h1);
    wait_done(lat);
    chk("maddu_latency", lat, 32'd34);
    chk("maddu_hi", bus.hi, 32'd0);
    chk("maddu_lo", bus.lo, 32'd17);
`else
    issue(3'd5, 32'd3, 32'd4);
    chk("op5_busy", {31'b0, bus.busy}, 32'h0);
    chk("op5_lo", bus.lo, 32'h5);
    chk("op5_hi", bus.hi, 32'h0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
